// File: rtl/nios_mem_stream_loader.sv
// Framed byte-stream loader for the Nios on-chip memory: parses sync/header/data/checksum,
// packs bytes little-endian into 32-bit words and issues single-cycle Avalon-MM writes.
module nios_mem_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DEPTH      = 5000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [15:0]           start_q, start_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            sum_q, sum_d;
    logic                  wr_q, wr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            code_q, code_d;

    logic                  accept;
    logic [7:0]            sum_next;
    logic [15:0]           hdr_cnt;
    logic [16:0]           range_end;

    // Ready depends only on state; the two internal cycles (CHECK, WRITE) stall the stream.
    assign in_ready = !reset && (state_q != S_CHECK) && (state_q != S_WRITE);
    assign accept   = in_valid && in_ready;
    assign sum_next = sum_q + in_data;
    assign hdr_cnt   = {in_data, cnt_q[7:0]};
    assign range_end = {1'b0, start_q} + {1'b0, hdr_cnt};

    assign mem_address    = addr_q;
    assign mem_byteenable = 4'hF;
    assign mem_chipselect = wr_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = code_q;

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        sum_d      = sum_q;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        code_d     = code_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d   = S_HDR;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    code_d    = ERR_NONE;
                    sum_d     = 8'd0;
                    hdr_idx_d = 2'd0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    sum_d     = sum_next;
                    hdr_idx_d = 2'(hdr_idx_q + 2'd1);
                    unique case (hdr_idx_q)
                        2'd0: start_d[7:0]  = in_data;
                        2'd1: start_d[15:8] = in_data;
                        2'd2: cnt_d[7:0]    = in_data;
                        default: begin
                            // Range is resolved here so done can be registered into the CHECK cycle.
                            cnt_d[15:8] = in_data;
                            remain_d    = hdr_cnt;
                            addr_d      = start_q[ADDR_WIDTH-1:0];
                            state_d     = S_CHECK;
                            if (range_end > 17'(DEPTH)) begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                error_d = 1'b1;
                                code_d  = ERR_RANGE;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                byte_idx_d = 2'd0;
                if (error_q) begin
                    state_d = S_IDLE;
                end else if (remain_q == 16'd0) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_d      = sum_next;
                    byte_idx_d = 2'(byte_idx_q + 2'd1);
                    unique case (byte_idx_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            wr_d    = 1'b1;
                            wdata_d = {in_data, word_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                addr_d   = ADDR_WIDTH'(addr_q + ADDR_WIDTH'(1));
                remain_d = remain_q - 16'd1;
                state_d  = (remain_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    sum_d   = sum_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (sum_next != 8'd0) begin
                        error_d = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 2'd0;
            start_q    <= 16'd0;
            cnt_q      <= 16'd0;
            remain_q   <= 16'd0;
            addr_q     <= '0;
            byte_idx_q <= 2'd0;
            word_q     <= 24'd0;
            sum_q      <= 8'd0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            code_q     <= code_d;
        end
    end

endmodule

// File: tb/tb_nios_mem_stream_loader.sv
// Scoreboard bench for nios_mem_stream_loader: frames are built from a word list, expected
// writes and completions are queued, and a negedge monitor pops and compares them.
module tb_nios_mem_stream_loader;

    localparam int unsigned ADDR_WIDTH = 13;
    localparam int unsigned DEPTH      = 5000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [3:0]            mem_byteenable;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [31:0]           mem_writedata;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            err_code;

    nios_mem_stream_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       err;
        logic [1:0] code;
        int         low;
    } done_t;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [31:0] words[$];
    int          checks     = 0;
    int          failures   = 0;
    int          done_seen  = 0;
    int          low_cnt    = 0;
    logic        prev_wr    = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every write strobe and every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            low_cnt = 0;
            prev_wr = 1'b0;
        end else begin
            if (!in_ready) low_cnt++;
            if (mem_write) begin
                check("strobe_one_cycle", 32'(prev_wr), 32'd0);
                check("chipselect", 32'(mem_chipselect), 32'd1);
                check("byteenable", 32'(mem_byteenable), 32'hF);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", 32'(mem_address), w.addr);
                    check("write_data", mem_writedata, w.data);
                end
            end
            prev_wr = mem_write;
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_error", 32'(error), 32'(d.err));
                    check("done_err_code", 32'(err_code), 32'(d.code));
                    check("ready_low_cycles", 32'(low_cnt), 32'(d.low));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
                low_cnt = 0;
                done_seen++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("send_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ctrl"}, {26'd0, mem_write, mem_chipselect, busy, done, error, 1'b0},
              32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_wdata"}, mem_writedata, 32'd0);
        check({tag, "_byteenable"}, 32'(mem_byteenable), 32'hF);
    endtask

    task automatic fill_random(input int unsigned n);
        words.delete();
        for (int i = 0; i < int'(n); i++) words.push_back($urandom());
    endtask

    // Reference model: build frame bytes from the word list and queue the expected outcome.
    // csum_mode: 0 correct, 1 forced 0x00, 2 deliberately wrong. trunc>=0 stops after that many data bytes.
    task automatic run_frame(input int unsigned start, input int unsigned n, input int csum_mode,
                             input bit gaps, input int trunc);
        logic [7:0] q[$];
        logic [7:0] s;
        logic [7:0] total;
        bit         range_bad;
        int         d0;
        int         t;
        q.push_back(8'(start));
        q.push_back(8'(start >> 8));
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        range_bad = (start + n) > DEPTH;
        if (!range_bad) begin
            for (int i = 0; i < int'(n); i++)
                for (int k = 0; k < 4; k++) q.push_back(8'(words[i] >> (8 * k)));
            s = 8'd0;
            foreach (q[i]) s = s + q[i];
            case (csum_mode)
                0:       q.push_back(8'(0 - s));
                1:       q.push_back(8'h00);
                default: q.push_back(8'(0 - s + $urandom_range(1, 255)));
            endcase
        end
        total = 8'd0;
        foreach (q[i]) total = total + q[i];
        if (trunc >= 0) begin
            for (int i = 0; i < trunc / 4 && i < int'(n); i++) exp_wr.push_back('{start + i, words[i]});
            q = q[0:3 + trunc];
        end else if (range_bad) begin
            exp_done.push_back('{1'b1, 2'b01, 1});
        end else begin
            for (int i = 0; i < int'(n); i++) exp_wr.push_back('{start + i, words[i]});
            exp_done.push_back('{total != 8'd0, (total != 8'd0) ? 2'b10 : 2'b00, 1 + int'(n)});
        end
        d0 = done_seen;
        send_byte(8'hA5, gaps);
        foreach (q[i]) send_byte(q[i], gaps);
        if (trunc < 0) begin
            t = 0;
            while (done_seen == d0 && t < 2000) begin
                @(posedge clk);
                t++;
            end
            if (t >= 2000) check("done_timeout", 32'(t), 32'd0);
            @(negedge clk);
            check("writes_drained", 32'(exp_wr.size()), 32'd0);
            check("dones_drained", 32'(exp_done.size()), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1 check_reset_vals("por");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Reference frame from the test plan, then the same frame with CSUM forced to 0x00
        words = '{32'h12345678, 32'hDEADBEEF};
        run_frame(32'h010, 2, 0, 1'b0, -1);
        run_frame(32'h010, 2, 1, 1'b0, -1);

        // Range boundary: 4998+3 overflows, 4998+2 fits exactly
        fill_random(3);
        run_frame(4998, 3, 0, 1'b0, -1);
        fill_random(2);
        run_frame(4998, 2, 0, 1'b0, -1);

        // Empty frame
        words.delete();
        run_frame(0, 0, 0, 1'b0, -1);

        // Junk before sync, then a 16-word frame with random valid gaps
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        fill_random(16);
        run_frame($urandom_range(0, DEPTH - 16), 16, 0, 1'b1, -1);

        // Reset after the 6th data byte, then a clean frame
        fill_random(4);
        run_frame(32'h100, 4, 0, 1'b0, 6);
        reset = 1'b1;
        #1 check_reset_vals("mid_frame");
        repeat (3) @(negedge clk);
        check_reset_vals("mid_frame_hold");
        check("reset_no_pending_writes", 32'(exp_wr.size()), 32'd0);
        #2 reset = 1'b0;
        fill_random(3);
        run_frame(32'h200, 3, 0, 1'b0, -1);

        // Randomised frames: mixed sizes, occasional range and checksum errors
        for (int i = 0; i < 12; i++) begin
            int unsigned n;
            int unsigned st;
            n = $urandom_range(0, 8);
            if ($urandom_range(0, 4) == 0) st = DEPTH - n + $urandom_range(1, 20);
            else st = $urandom_range(0, DEPTH - n);
            fill_random(n);
            run_frame(st, n, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)), -1);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_mem_stream_loader.md
# nios_mem_stream_loader

Byte-stream loader that sits directly upstream of the Nios on-chip memory (5000 × 32-bit, 13-bit word address) and drives its Avalon-MM slave write port. It parses a framed byte stream (sync, start address, word count, data, checksum), packs bytes little-endian into 32-bit words, and issues one single-cycle write per word. It reports completion and errors so a debug or boot host can load program or data images without the CPU.

## Interface
Parameters:
- ADDR_WIDTH, 13, memory word-address width.
- DEPTH, 5000, memory size in words; used for range checking.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid & in_ready.
- mem_address  out  ADDR_WIDTH  word address to the memory.
- mem_byteenable  out  4  constant 4'hF.
- mem_chipselect  out  1  asserted together with mem_write.
- mem_write  out  1  single-cycle write strobe.
- mem_writedata  out  32  packed word.
- busy  out  1  high from sync-byte acceptance until the done pulse.
- done  out  1  one-cycle pulse at frame end, whether good or bad.
- error  out  1  valid with done; held until the next sync byte is accepted.
- err_code  out  2  00 none, 01 range, 10 checksum; held like error.

## Operation
Frame byte order:
- 0xA5 sync.
- ADDR_LO, ADDR_HI.
- CNT_LO, CNT_HI (N words, 0..65535).
- 4·N data bytes, LSB first per word.
- CSUM: sum of all bytes after sync, including CSUM, is 0 mod 256.

States:
- IDLE: in_ready=1. Bytes other than 0xA5 are discarded. On 0xA5: go to HDR, busy=1, clear error and err_code, clear running sum.
- HDR: accepts 4 bytes into start[15:0] and cnt[15:0]; then go to CHECK.
- CHECK: one cycle, in_ready=0. If start + cnt > DEPTH (17-bit compare), pulse done with error=1 and err_code=01, then go to IDLE; no writes occur. Else, if cnt==0 go to CSUM, otherwise go to DATA.
- DATA: accepts bytes into the packer. After the 4th byte of a word, go to WRITE.
- WRITE: one cycle, in_ready=0. Drive mem_write=mem_chipselect=1 with mem_address=current address and mem_writedata=packed word. Then increment the address and decrement the remaining count. Go to DATA, or to CSUM if the count reaches 0.
- CSUM: accepts 1 byte. Next cycle: done=1 with error and err_code=10 if the sum is nonzero mod 256, busy=0, go to IDLE. Words already written are not rolled back.

Rules:
- The running sum is 8-bit wrap-around and covers every accepted byte after sync.
- mem_address is taken from start[ADDR_WIDTH-1:0]. The range check guarantees the address never wraps.
- Gaps in in_valid are allowed in any state; the state is held while no byte transfers.

## Timing
- Reset values: state IDLE; mem_write, mem_chipselect, busy, done, error, err_code, mem_address and mem_writedata all 0; mem_byteenable 4'hF.
- in_ready is forced to 0 while reset is asserted and becomes 1 in the first cycle after deassertion.
- All mem_* outputs, done, error and err_code are registered.
- in_ready is decoded from the state. It is 0 only in CHECK and WRITE.
- The write strobe asserts in the cycle after the 4th byte of a word is accepted, and lasts exactly one cycle.
- Peak throughput is 4 bytes per 5 cycles.
- done asserts in the cycle after the CSUM byte is accepted, or in the CHECK cycle for a range error.
- The next sync byte can be accepted in the cycle after done.
- Reset mid-frame: outputs return to their reset values immediately. A write strobe in progress is cancelled. The partial frame is lost, and the next frame must start with sync.

## Test plan
- Good frame: A5 10 00 02 00 78 56 34 12 EF BE AD DE A2 -> writes 0x12345678 at 0x010 and 0xDEADBEEF at 0x011; each strobe is 1 cycle; done=1, error=0.
- Same frame with CSUM=00 -> both writes occur; done=1, error=1, err_code=10.
- Range: start 0x1386 (4998), N=3 -> done=1, err_code=01, zero writes. Start 4998, N=2 with correct CSUM -> writes at 0x1386 and 0x1387, no error.
- N=0: A5 00 00 00 00 00 -> done, error=0, zero writes.
- Bytes 00 FF 5A before sync are ignored. Random in_valid gaps through a 16-word frame -> correct words and addresses; in_ready is low exactly in CHECK and each WRITE cycle.
- Reset asserted after the 6th data byte -> no further mem_write and all outputs at reset values. A following good frame loads correctly.
